// File: rtl/moving_avg_pkg.sv
// Shared constants and helpers for the moving-average filter and its decoder.
package moving_avg_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_SHIFT = 4;

  function automatic int sumWidth(input int width, input int shift);
    return width + shift;
  endfunction

  // Sign-extends the low 'width' bits of value to the full 64 bits.
  function automatic logic [63:0] signExtend(input logic [63:0] value, input int width);
    logic signed [63:0] shifted;
    shifted = value << (64 - width);
    return shifted >>> (64 - width);
  endfunction
endpackage

// File: rtl/sample_history_ram.sv
// N x WIDTH circular buffer of recovered samples: read and write share one
// pointer that wraps N-1 -> 0; a clear may coincide with a write into slot 0.
import moving_avg_pkg::*;

module sample_history_ram #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SHIFT = DEFAULT_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [0:N-1];
  logic [SHIFT-1:0] r_ptr;

  // A clear with a write lands the value as the first sample of the new stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (i_clr) begin
      for (int i = 1; i < N; i++) r_mem[i] <= '0;
      r_mem[0] <= i_we ? i_wdata : '0;
      r_ptr    <= i_we ? SHIFT'(1) : '0;
    end else if (i_we) begin
      r_mem[r_ptr] <= i_wdata;
      r_ptr        <= r_ptr + SHIFT'(1);
    end
  end

  assign o_rdata = r_mem[r_ptr];
endmodule

// File: rtl/moving_sum_decoder.sv
// Reconstructs samples from a full-precision N-tap moving-sum stream:
// x[n] = s[n] - s[n-1] + x[n-N]. Optional range flag: MOVING_SUM_DECODER_ERR_EN.
import moving_avg_pkg::*;

module moving_sum_decoder #(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter int  N         = DEFAULT_N,
  parameter int  SHIFT     = DEFAULT_SHIFT,
  localparam int SUM_WIDTH = sumWidth(WIDTH, SHIFT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [SUM_WIDTH-1:0] in_sum,
  input  logic                        sync_clr,
  output logic                        out_valid,
  output logic signed [WIDTH-1:0]     out_sample,
  output logic                        window_full
`ifdef MOVING_SUM_DECODER_ERR_EN
  ,
  output logic                        err_sticky
`endif
);
  localparam int DW = SUM_WIDTH + 1;
  localparam int RW = SUM_WIDTH + 2;
  localparam logic [SHIFT:0] COUNT_FULL = (SHIFT + 1)'(N);

  logic signed [SUM_WIDTH-1:0] r_prevSum;
  logic [SHIFT:0]              r_count;
  logic                        r_outValid;
  logic signed [WIDTH-1:0]     r_outSample;
  logic                        r_windowFull;

  logic [WIDTH-1:0]            w_histRd;
  logic [WIDTH-1:0]            w_histEff;
  logic signed [SUM_WIDTH-1:0] w_prevEff;
  logic signed [DW-1:0]        w_diff;
  logic signed [RW-1:0]        w_histExt;
  logic signed [RW-1:0]        w_rec;
  logic [WIDTH-1:0]            w_recLow;
  logic [SHIFT:0]              w_countNext;

  sample_history_ram #(
    .WIDTH (WIDTH),
    .N     (N),
    .SHIFT (SHIFT)
  ) u_history (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (sync_clr),
    .i_we    (in_valid),
    .i_wdata (w_recLow),
    .o_rdata (w_histRd)
  );

  // A coincident clear decodes against an all-zero history and zero previous sum.
  always_comb begin
    w_histEff = sync_clr ? '0 : w_histRd;
    w_prevEff = sync_clr ? '0 : r_prevSum;
    w_diff    = DW'(in_sum) - DW'(w_prevEff);
    w_histExt = RW'(signExtend(64'(w_histEff), WIDTH));
    w_rec     = RW'(w_diff) + w_histExt;
    w_recLow  = WIDTH'(w_rec);

    w_countNext = r_count;
    if (sync_clr) begin
      w_countNext = in_valid ? (SHIFT + 1)'(1) : '0;
    end else if (in_valid && (r_count != COUNT_FULL)) begin
      w_countNext = r_count + (SHIFT + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevSum    <= '0;
      r_count      <= '0;
      r_outValid   <= 1'b0;
      r_outSample  <= '0;
      r_windowFull <= 1'b0;
    end else begin
      r_outValid   <= in_valid;
      r_count      <= w_countNext;
      r_windowFull <= (w_countNext == COUNT_FULL);
      if (in_valid) begin
        r_outSample <= w_recLow;
        r_prevSum   <= in_sum;
      end else if (sync_clr) begin
        r_prevSum <= '0;
      end
    end
  end

  assign out_valid   = r_outValid;
  assign out_sample  = r_outSample;
  assign window_full = r_windowFull;

`ifdef MOVING_SUM_DECODER_ERR_EN
  logic w_recBad;
  logic r_err;

  // rec fits WIDTH only when every bit from the WIDTH-1 sign bit upward agrees.
  assign w_recBad = !((&w_rec[RW-1:WIDTH-1]) || !(|w_rec[RW-1:WIDTH-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (sync_clr) begin
      r_err <= in_valid && w_recBad;
    end else if (in_valid && w_recBad) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;
`endif
endmodule

// File: tb/tb_moving_sum_decoder.sv
// Directed, table-driven bench for moving_sum_decoder (default WIDTH=16, N=16).
module tb_moving_sum_decoder;
  localparam int SUM_WIDTH = 20;

  typedef struct {
    logic valid;
    logic clr;
    int   sum;
    logic expValid;
    int   expSample;
    logic expFull;
  } vec_t;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic signed [SUM_WIDTH-1:0] in_sum;
  logic                        sync_clr;
  logic                        out_valid;
  logic signed [15:0]          out_sample;
  logic                        window_full;
`ifdef MOVING_SUM_DECODER_ERR_EN
  logic                        err_sticky;
`endif

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs[$];

  moving_sum_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sum      (in_sum),
    .sync_clr    (sync_clr),
    .out_valid   (out_valid),
    .out_sample  (out_sample),
    .window_full (window_full)
`ifdef MOVING_SUM_DECODER_ERR_EN
    ,
    .err_sticky  (err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkOutput(input string name, input logic expValid, input int expSample,
                             input logic expFull);
    compareVal({name, ".out_valid"}, int'(out_valid), int'(expValid));
    compareVal({name, ".out_sample"}, int'(out_sample), expSample);
    compareVal({name, ".window_full"}, int'(window_full), int'(expFull));
  endtask

  // Drives one cycle of inputs, then samples the outputs 1 ns after the edge.
  task automatic applyStimulus(input logic valid, input logic clr, input int sum);
    in_valid = valid;
    sync_clr = clr;
    in_sum   = SUM_WIDTH'(sum);
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic v, input logic c, input int s,
                                 input logic ev, input int es, input logic ef);
    vec_t t;
    t.valid = v; t.clr = c; t.sum = s;
    t.expValid = ev; t.expSample = es; t.expFull = ef;
    vecs.push_back(t);
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    sync_clr = 1'b0;
    in_sum = '0;

    // Ramp with gaps, wrap past 16 samples, negative extreme, clear variants.
    addVec(1, 0, 1, 1, 1, 0);
    addVec(1, 0, 3, 1, 2, 0);
    addVec(1, 0, 6, 1, 3, 0);
    addVec(0, 0, 999, 0, 3, 0);
    addVec(1, 0, 10, 1, 4, 0);
    addVec(0, 0, -7, 0, 4, 0);
    for (int x = 5; x <= 15; x++) addVec(1, 0, x * (x + 1) / 2, 1, x, 0);
    addVec(1, 0, 136, 1, 16, 1);
    addVec(1, 0, 152, 1, 17, 1);
    addVec(1, 0, 250, 1, 100, 1);
    addVec(0, 0, 0, 0, 100, 1);
    addVec(1, 1, -32768, 1, -32768, 0);
    addVec(1, 0, -32768, 1, 0, 0);
    addVec(1, 1, 5, 1, 5, 0);
    addVec(0, 1, 77, 0, 5, 0);
    addVec(1, 0, 7, 1, 7, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].clr, vecs[i].sum);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expSample, vecs[i].expFull);
    end

    // Mid-stream reset after sample 10, then restart from zero history.
    applyStimulus(0, 1, 0);
    for (int x = 1; x <= 10; x++) applyStimulus(1, 0, x * (x + 1) / 2);
    compareVal("pre_reset.out_sample", int'(out_sample), 10);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("post_reset_idle", 1'b0, 0, 1'b0);
    applyStimulus(1, 0, 4);
    checkOutput("restart0", 1'b1, 4, 1'b0);
    applyStimulus(1, 0, 9);
    checkOutput("restart1", 1'b1, 5, 1'b0);

    // Out-of-range reconstruction truncates to the low 16 bits.
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("range0", 1'b1, 0, 1'b0);
`ifdef MOVING_SUM_DECODER_ERR_EN
    compareVal("range0.err_sticky", int'(err_sticky), 0);
`endif
    applyStimulus(1, 0, 40000);
    checkOutput("range_bad", 1'b1, -25536, 1'b0);
`ifdef MOVING_SUM_DECODER_ERR_EN
    compareVal("range_bad.err_sticky", int'(err_sticky), 1);
`endif
    applyStimulus(1, 0, 40000);
    checkOutput("range_hold", 1'b1, 0, 1'b0);
`ifdef MOVING_SUM_DECODER_ERR_EN
    compareVal("range_hold.err_sticky", int'(err_sticky), 1);
`endif
    applyStimulus(0, 1, 0);
    checkOutput("range_clr", 1'b0, 0, 1'b0);
`ifdef MOVING_SUM_DECODER_ERR_EN
    compareVal("range_clr.err_sticky", int'(err_sticky), 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
